muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 23 ++
 rtl/div_step.sv | 25 ++
 rtl/muldiv_sequencer.sv | 175 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states,
// iteration count and the sign-magnitude helper.
package muldiv_sequencer_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the remainder,
// subtract the divisor, keep the difference if it did not go negative.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULTU/DIV/DIVU sequencer: 32 radix-2 steps on magnitudes plus a sign fix.
// Define MULDIV_DIVZERO_EXC_EN to add dz_exc and suppress HI/LO writes on divide by zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hi_w,
  output logic        lo_w
`ifdef MULDIV_DIVZERO_EXC_EN
  ,
  output logic        dz_exc
`endif
);
  state_t      state_q;
  logic        arm_q, is_div_q, neg_res_q, neg_rem_q, dz_q;
  logic [4:0]  count_q;
  logic [31:0] a_raw_q, m_q, acc_hi_q, acc_lo_q;
  logic        busy_q, done_q, hi_w_q, lo_w_q;
  logic [31:0] hi_q, lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic        dz_exc_q;
`endif

  logic        sgn_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [31:0] div_rem, div_quo;
  logic [63:0] prod, prod_neg;
  logic [31:0] res_hi, res_lo;
  logic        last_step;

  assign sgn_in    = (op == OP_MUL) || (op == OP_DIV);
  assign mag_a     = mag32(a, sgn_in);
  assign mag_b     = mag32(b, sgn_in);
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : 33'd0);
  assign last_step = (count_q == 5'(ITER_COUNT - 1));

  div_step u_div_step (
    .rem_i (acc_hi_q),
    .quo_i (acc_lo_q),
    .div_i (m_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_neg = ~prod + 64'd1;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    if (!is_div_q) begin
      {res_hi, res_lo} = neg_res_q ? prod_neg : prod;
    end else if (dz_q) begin
      res_hi = a_raw_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_lo = neg_res_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
      res_hi = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
    end
  end

  // Operands are captured on the accepting edge; RUN begins on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      arm_q     <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      count_q   <= 5'd0;
      a_raw_q   <= 32'd0;
      m_q       <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_w_q    <= 1'b0;
      lo_w_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
`ifdef MULDIV_DIVZERO_EXC_EN
      dz_exc_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      hi_w_q <= 1'b0;
      lo_w_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EXC_EN
      dz_exc_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (arm_q) begin
            arm_q   <= 1'b0;
            state_q <= StRun;
            busy_q  <= 1'b1;
            count_q <= 5'd0;
          end else if (start && !cancel) begin
            arm_q     <= 1'b1;
            is_div_q  <= op[1];
            neg_res_q <= sgn_in && (a[31] ^ b[31]);
            neg_rem_q <= sgn_in && a[31];
            dz_q      <= op[1] && (b == 32'd0);
            a_raw_q   <= a;
            m_q       <= op[1] ? mag_b : mag_a;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= op[1] ? mag_a : mag_b;
          end
        end
        StRun: begin
          if (cancel) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              acc_hi_q <= div_rem;
              acc_lo_q <= div_quo;
            end else begin
              acc_hi_q <= mul_sum[32:1];
              acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
            end
            count_q <= count_q + 5'd1;
            if (last_step) state_q <= StFix;
          end
        end
        StFix: begin
          busy_q  <= 1'b0;
          state_q <= cancel ? StIdle : StDone;
          if (!cancel) begin
            done_q <= 1'b1;
`ifdef MULDIV_DIVZERO_EXC_EN
            if (dz_q) begin
              dz_exc_q <= 1'b1;
            end else begin
              hi_q   <= res_hi;
              lo_q   <= res_lo;
              hi_w_q <= 1'b1;
              lo_w_q <= 1'b1;
            end
`else
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            hi_w_q <= 1'b1;
            lo_w_q <= 1'b1;
`endif
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign hi_w = hi_w_q;
  assign lo_w = lo_w_q;
`ifdef MULDIV_DIVZERO_EXC_EN
  assign dz_exc = dz_exc_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, randomized ops against an
// arithmetic reference model, cancel, reset and start-in-DONE scenarios.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, hi_w, lo_w;
  logic [31:0] hi, lo;
  logic        dz_val;

`ifdef MULDIV_DIVZERO_EXC_EN
  localparam bit EXC_EN = 1'b1;
  logic dz_exc;
  assign dz_val = dz_exc;
`else
  localparam bit EXC_EN = 1'b0;
  assign dz_val = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  always #5 clk = ~clk;

  muldiv_sequencer u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .hi_w   (hi_w),
    .lo_w   (lo_w)
`ifdef MULDIV_DIVZERO_EXC_EN
    ,
    .dz_exc (dz_exc)
`endif
  );

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ew, output logic edz);
    longint sx, sy, p, r;
    longint unsigned ux, uy, up;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    ew  = 1'b1;
    edz = 1'b0;
    eh  = 32'd0;
    el  = 32'd0;
    if (o == 2'b00) begin
      p = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else if (o == 2'b01) begin
      up = ux * uy;
      eh = up[63:32];
      el = up[31:0];
    end else if (y == 32'd0) begin
      edz = EXC_EN;
      ew  = !EXC_EN;
      eh  = EXC_EN ? prev_hi : x;
      el  = EXC_EN ? prev_lo : 32'hFFFF_FFFF;
    end else if (o == 2'b10) begin
      p = sx / sy;
      r = sx % sy;
      eh = r[31:0];
      el = p[31:0];
    end else begin
      up = ux / uy;
      eh = 32'(ux % uy);
      el = up[31:0];
    end
  endtask

  // Issues one op and reports what it observed; lat stays 0 if done never arrives.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt, output logic b0, output logic bd,
                       output logic [31:0] gh, output logic [31:0] gl,
                       output logic ghw, output logic glw, output logic gdz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    b0 = busy; bd = 1'b1; lat = 0; bcnt = 0;
    gh = 32'd0; gl = 32'd0; ghw = 1'b0; glw = 1'b0; gdz = 1'b0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; bd = busy; gh = hi; gl = lo; ghw = hi_w; glw = lo_w; gdz = dz_val;
      end else if (busy) begin
        bcnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    #1;
    total++;
    if ({busy, done, hi_w, lo_w, dz_val, hi, lo} !== 69'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b hw=%b lw=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, hi_w, lo_w, dz_val, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [1:0]  vo [5] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b11};
    logic [31:0] va [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h8000_0000, 32'd100};
    logic [31:0] vb [5] = '{32'd2, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vh [5] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd100};
    logic [31:0] vl [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFF1, 32'h8000_0000,
                            32'hFFFF_FFFF};
    int lat, bcnt;
    logic b0, bd, ghw, glw, gdz, ew;
    logic [31:0] gh, gl, eh, el;
    for (int i = 0; i < 5; i++) begin
      do_op(vo[i], va[i], vb[i], lat, bcnt, b0, bd, gh, gl, ghw, glw, gdz);
      eh = vh[i]; el = vl[i]; ew = 1'b1;
      if (i == 4 && EXC_EN) begin
        eh = prev_hi; el = prev_lo; ew = 1'b0;
      end
      total++;
      if (lat !== 34 || bcnt !== 33 || b0 !== 1'b0 || bd !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_timing got lat=%0d busy_cycles=%0d busy0=%b busy_done=%b want 34 33 0 0",
                 i, lat, bcnt, b0, bd);
      end
      total++;
      if (gh !== eh || gl !== el) begin
        bad++;
        $display("FAIL vec%0d_result got hi=%h lo=%h want hi=%h lo=%h", i, gh, gl, eh, el);
      end
      total++;
      if (ghw !== ew || glw !== ew || gdz !== (i == 4 && EXC_EN)) begin
        bad++;
        $display("FAIL vec%0d_strobes got hw=%b lw=%b dz=%b want hw=lw=%b", i, ghw, glw, gdz, ew);
      end
      if (ew) begin
        prev_hi = eh; prev_lo = el;
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic b0, bd, ghw, glw, gdz, ew, edz;
    logic [31:0] gh, gl, eh, el, x, y;
    logic [1:0] o;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = 32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      model(o, x, y, eh, el, ew, edz);
      do_op(o, x, y, lat, bcnt, b0, bd, gh, gl, ghw, glw, gdz);
      total++;
      if (lat !== 34 || gh !== eh || gl !== el || ghw !== ew || glw !== ew || gdz !== edz) begin
        bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h hw=%b lw=%b dz=%b want 34 %h %h %b %b",
                 i, o, x, y, lat, gh, gl, ghw, glw, gdz, eh, el, ew, edz);
      end
      if (ew) begin
        prev_hi = eh; prev_lo = el;
      end
    end
  endtask

  task automatic test_cancel();
    int lat, bcnt, seen;
    logic b0, bd, ghw, glw, gdz;
    logic [31:0] gh, gl;
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL cancel_busy_before got %b want 1", busy);
    end
    @(negedge clk);
    cancel = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cancel_to_idle got busy=%b want 0", busy);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || hi_w || hi !== prev_hi || lo !== prev_lo) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL cancel_quiet got %0d active cycles want 0", seen);
    end
    do_op(2'b11, 32'd9, 32'd4, lat, bcnt, b0, bd, gh, gl, ghw, glw, gdz);
    total++;
    if (lat !== 34 || gh !== 32'd1 || gl !== 32'd2 || ghw !== 1'b1) begin
      bad++;
      $display("FAIL cancel_then_divu got lat=%0d hi=%h lo=%h hw=%b want 34 1 2 1", lat, gh, gl, ghw);
    end
    prev_hi = 32'd1; prev_lo = 32'd2;
    // start and cancel together in IDLE must not launch anything
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b00; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    total++;
    if (seen !== 0 || lo !== prev_lo) begin
      bad++;
      $display("FAIL cancel_wins_start got %0d active cycles lo=%h want 0 %h", seen, lo, prev_lo);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic b0, bd, ghw, glw, gdz, ew, edz;
    logic [31:0] gh, gl, eh, el;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_running got busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got busy=%b hi=%h lo=%h done=%b want 0 0 0 0", busy, hi, lo, done);
    end
    #1;
    rst = 1'b0;
    prev_hi = 32'd0; prev_lo = 32'd0;
    model(2'b00, 32'hFFFF_0001, 32'h0001_0003, eh, el, ew, edz);
    do_op(2'b00, 32'hFFFF_0001, 32'h0001_0003, lat, bcnt, b0, bd, gh, gl, ghw, glw, gdz);
    total++;
    if (lat !== 34 || bcnt !== 33 || gh !== eh || gl !== el) begin
      bad++;
      $display("FAIL rstmid_after got lat=%0d busy_cycles=%0d hi=%h lo=%h want 34 33 %h %h",
               lat, bcnt, gh, gl, eh, el);
    end
    prev_hi = eh; prev_lo = el;
  endtask

  task automatic test_start_in_done();
    int lat, bcnt, seen;
    logic b0, bd, ghw, glw, gdz, ew, edz;
    logic [31:0] gh, gl, eh, el;
    model(2'b10, 32'd1000, 32'hFFFF_FFF9, eh, el, ew, edz);
    do_op(2'b10, 32'd1000, 32'hFFFF_FFF9, lat, bcnt, b0, bd, gh, gl, ghw, glw, gdz);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (lat !== 34 || gh !== eh || gl !== el) begin
      bad++;
      $display("FAIL sid_op got lat=%0d hi=%h lo=%h want 34 %h %h", lat, gh, gl, eh, el);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    total++;
    if (seen !== 0 || lo !== el) begin
      bad++;
      $display("FAIL start_in_done got %0d active cycles lo=%h want 0 %h", seen, lo, el);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_cancel();
    test_reset_mid();
    test_start_in_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
